// File: rtl/motor_pkg.sv
// Shared types and helpers for the multi-channel H-bridge PWM driver.
package motor_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      DEAD  = 3'd2,
      COOL  = 3'd3,
      FAULT = 3'd4
   } ch_state_e;

   localparam logic FWD = 1'b0;
   localparam logic REV = 1'b1;

   // Width able to hold max(a, b) - 1; never narrower than one bit.
   function automatic int clog2_max(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      if (m < 2) begin
         return 1;
      end else begin
         return $clog2(m);
      end
   endfunction

endpackage

// File: rtl/motor_channel_fsm.sv
// One H-bridge channel: duty latch, PWM compare, run/dead/cooldown/fault FSM
// and the registered leg pair.
module motor_channel_fsm
   import motor_pkg::*;
#(
   parameter int PWM_BITS        = 8,
   parameter int DEAD_CYCLES     = 1000,
   parameter int COOLDOWN_CYCLES = 100000,
   parameter int MAX_RETRY       = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [PWM_BITS-1:0] pwm_cnt_i,
   input  logic                period_start_i,
   input  logic [PWM_BITS-1:0] duty_i,
   input  logic                dir_i,
   input  logic                enable_i,
   input  logic                oc_i,
   input  logic                fault_clr_i,
   output logic [1:0]          in_o,
   output logic                fault_o,
   output logic                busy_o
);

   localparam int TMR_W = clog2_max(DEAD_CYCLES, COOLDOWN_CYCLES);
   localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [TMR_W-1:0] DEAD_LOAD = TMR_W'(DEAD_CYCLES - 1);
   localparam logic [TMR_W-1:0] COOL_LOAD = TMR_W'(COOLDOWN_CYCLES - 1);
   localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);

   ch_state_e           state_q, state_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [RTY_W-1:0]    retry_q, retry_d;
   logic                dir_lat_q, dir_lat_d;
   logic [PWM_BITS-1:0] duty_lat_q, duty_lat_d;
   logic [1:0]          in_q, in_d;
   logic                fault_q, fault_d;
   logic                busy_q, busy_d;
   logic                pwm_on;

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      retry_d   = retry_q;
      dir_lat_d = dir_lat_q;
      pwm_on    = (pwm_cnt_i < duty_lat_q);

      // Duty only changes on the period boundary so a period never glitches.
      if (period_start_i) begin
         duty_lat_d = duty_i;
      end else begin
         duty_lat_d = duty_lat_q;
      end

      case (state_q)
         IDLE: begin
            if (enable_i) begin
               state_d   = RUN;
               dir_lat_d = dir_i;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (oc_i) begin
               if (retry_q < RTY_MAX) begin
                  retry_d = retry_q + 1'b1;
                  timer_d = COOL_LOAD;
                  state_d = COOL;
               end else begin
                  state_d = FAULT;
               end
            end else if (!enable_i) begin
               state_d = IDLE;
               retry_d = '0;
            end else if (dir_i != dir_lat_q) begin
               timer_d = DEAD_LOAD;
               state_d = DEAD;
            end else begin
               state_d = RUN;
            end
         end
         DEAD, COOL: begin
            if (timer_q == '0) begin
               if (enable_i) begin
                  state_d   = RUN;
                  dir_lat_d = dir_i;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         FAULT: begin
            if (fault_clr_i) begin
               state_d = IDLE;
               retry_d = '0;
            end else begin
               state_d = FAULT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      in_d = 2'b00;
      if (state_q == RUN) begin
         if (dir_lat_q) begin
            in_d[REV] = pwm_on;
         end else begin
            in_d[FWD] = pwm_on;
         end
      end else begin
         in_d = 2'b00;
      end
      busy_d  = (state_q == DEAD) || (state_q == COOL);
      fault_d = (state_q == FAULT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         retry_q    <= '0;
         dir_lat_q  <= 1'b0;
         duty_lat_q <= '0;
         in_q       <= 2'b00;
         fault_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         retry_q    <= retry_d;
         dir_lat_q  <= dir_lat_d;
         duty_lat_q <= duty_lat_d;
         in_q       <= in_d;
         fault_q    <= fault_d;
         busy_q     <= busy_d;
      end
   end

   assign in_o    = in_q;
   assign fault_o = fault_q;
   assign busy_o  = busy_q;

endmodule

// File: rtl/multi_motor_pwm_driver.sv
// N-channel H-bridge PWM driver: shared prescaler and PWM counter feeding
// one independent channel FSM per motor.
module multi_motor_pwm_driver
   import motor_pkg::*;
#(
   parameter int NUM_CH          = 2,
   parameter int PWM_BITS        = 8,
   parameter int PRESCALE        = 4,
   parameter int DEAD_CYCLES     = 1000,
   parameter int COOLDOWN_CYCLES = 100000,
   parameter int MAX_RETRY       = 3
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_CH*PWM_BITS-1:0] duty_in,
   input  logic [NUM_CH-1:0]          dir_in,
   input  logic [NUM_CH-1:0]          enable,
   input  logic [NUM_CH-1:0]          oc_in,
   input  logic [NUM_CH-1:0]          fault_clr,
   output logic [2*NUM_CH-1:0]        IN,
   output logic [NUM_CH-1:0]          fault,
   output logic [NUM_CH-1:0]          busy
);

   localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

   logic [PSC_W-1:0]    presc_q, presc_d;
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic                tick;
   logic                period_start;

   assign tick         = (presc_q == PSC_LAST);
   assign period_start = tick && (pwm_cnt_q == {PWM_BITS{1'b1}});

   always_comb begin
      if (tick) begin
         presc_d   = '0;
         pwm_cnt_d = pwm_cnt_q + 1'b1;
      end else begin
         presc_d   = presc_q + 1'b1;
         pwm_cnt_d = pwm_cnt_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc_q   <= '0;
         pwm_cnt_q <= '0;
      end else begin
         presc_q   <= presc_d;
         pwm_cnt_q <= pwm_cnt_d;
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      motor_channel_fsm #(
         .PWM_BITS       (PWM_BITS),
         .DEAD_CYCLES    (DEAD_CYCLES),
         .COOLDOWN_CYCLES(COOLDOWN_CYCLES),
         .MAX_RETRY      (MAX_RETRY)
      ) u_ch (
         .clk           (clk),
         .rst_n         (reset),
         .pwm_cnt_i     (pwm_cnt_q),
         .period_start_i(period_start),
         .duty_i        (duty_in[k*PWM_BITS +: PWM_BITS]),
         .dir_i         (dir_in[k]),
         .enable_i      (enable[k]),
         .oc_i          (oc_in[k]),
         .fault_clr_i   (fault_clr[k]),
         .in_o          (IN[2*k +: 2]),
         .fault_o       (fault[k]),
         .busy_o        (busy[k])
      );
   end

endmodule
